branch_predictor: RTL and testbench
===================================

# branch_predictor

Branch prediction table for the fetch stage, paired with the execute-stage branch comparator. Fetch sends a PC and receives a registered taken/not-taken prediction with a target one cycle later. Execute writes back each resolved outcome (`branch_taken` plus the computed target) to train the table. The block uses a direct-mapped array of tagged entries, each holding a 2-bit saturating counter and a stored target. It also keeps a saturating mispredict counter for performance monitoring.

## Interface
Parameters:
- `INDEX_BITS`, default 6: table has 2^INDEX_BITS entries; index = pc[INDEX_BITS+1:2].
- `CNT_WIDTH`, default 16: width of the mispredict statistic counter.

Ports:
- `clk`  input  1  — the single clock; all state updates on its rising edge.
- `rst`  input  1  — synchronous, active-high reset.
- `lookup_valid`  input  1  — fetch requests a prediction this cycle.
- `lookup_pc`  input  32  — PC of the instruction being fetched.
- `pred_valid`  output  1  — registered; high one cycle after `lookup_valid`.
- `pred_taken`  output  1  — registered prediction.
- `pred_target`  output  32  — registered predicted next PC.
- `upd_valid`  input  1  — a resolved branch is written back this cycle.
- `upd_pc`  input  32  — PC of the resolved branch.
- `upd_taken`  input  1  — actual outcome from the branch comparator.
- `upd_target`  input  32  — actual branch target computed in execute.
- `upd_pred_taken`  input  1  — prediction that was used for this branch, carried down the pipeline.
- `mispredict_count`  output  CNT_WIDTH  — saturating count of mispredicted updates.

## Operation
- Entry fields: `valid` (1), `tag` (pc[31:INDEX_BITS+2], 30-INDEX_BITS bits), `ctr` (2), `target` (32).
- `valid` bits live in a flop vector cleared by `rst`. `tag`, `ctr` and `target` are not reset and are meaningful only when `valid` is set.
- Hit: entry[idx].valid && entry[idx].tag == tag(pc).
- Lookup, latched when `lookup_valid` is high:
  - `pred_taken` = hit && ctr[1].
  - `pred_target` = the stored target when the prediction is taken; otherwise lookup_pc + 4, with 32-bit wrap (0xFFFFFFFC + 4 = 0x00000000).
- When `lookup_valid` is low: `pred_valid` = 0 next cycle, and `pred_taken`/`pred_target` hold their previous values.
- Update on hit:
  - Counter saturates: taken → min(ctr+1, 3); not taken → max(ctr-1, 0).
  - If `upd_taken`, overwrite `target` with `upd_target`.
- Update on miss (invalid entry or tag mismatch): allocate and replace.
  - valid = 1, tag = tag(upd_pc), target = upd_target.
  - ctr = 2'b10 if `upd_taken`, else 2'b01.
- Mispredict: when `upd_valid` && (upd_pred_taken != upd_taken), `mispredict_count` increments. It saturates at all-ones.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

## Timing
- Lookup latency is 1 cycle: `lookup_pc` sampled at edge N produces `pred_*` valid after edge N.
- Update latency is 1 cycle: a lookup issued in the cycle after an update sees the new entry state.
- Simultaneous lookup and update to the same index in the same cycle: the lookup uses the pre-update entry (read-before-write), and the update still commits.
- Lookup and update are independent; both may be active every cycle with no stall or backpressure.
- Reset, synchronous on the rising edge while `rst`=1:
  - All `valid` bits = 0, `pred_valid` = 0, `pred_taken` = 0, `pred_target` = 32'h0, `mispredict_count` = 0.
  - Lookups and updates presented during reset are ignored.
- Reset mid-operation discards all training. The first lookup after reset deasserts always misses and predicts not-taken with target pc+4.

## Test plan
- **Cold miss:** after reset, lookup pc=0x100 → next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
- **Allocate and train:**
  - update pc=0x100, taken=1, target=0x200 → lookup 0x100 gives taken=1, target=0x200.
  - Then update not-taken twice → lookup gives taken=0, target=0x104.
- **Saturation:** five taken updates to pc=0x40, then one not-taken → still predicts taken (ctr goes 3→2). A second not-taken → predicts not-taken.
- **Alias replace:**
  - train pc=0x100 taken (INDEX_BITS=6).
  - update pc=0x200, taken=0 (same index, different tag).
  - Result: lookup 0x100 → taken=0, target=0x104 (miss); lookup 0x200 → taken=0.
- **Same-cycle collision:** entry for 0x100 at weak-NT; in one cycle, lookup 0x100 and update 0x100 taken=1. The prediction in that cycle is taken=0; the next lookup predicts taken=1.
- **Mispredict counter and reset:**
  - 3 updates with upd_pred_taken≠upd_taken plus 2 matching → mispredict_count=3.
  - Assert rst one cycle → count=0, pred_valid=0, and a lookup of 0x100 misses.
  - With CNT_WIDTH=4, 20 mispredicts → count holds at 15.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor
// Direct-mapped, tagged branch prediction table with 2-bit saturating
// counters and stored targets. Fetch looks up a PC and gets a registered
// prediction one cycle later; execute writes back resolved outcomes to train
// the table. A saturating counter tracks mispredicted updates.
//
// Handshake semantics: there is no backpressure on either port. lookup_valid
// and upd_valid are single-cycle qualifiers sampled on every rising edge;
// pred_valid is a one-cycle pulse aligned with the registered pred_* fields.
// Both ports may fire every cycle, including to the same index, in which case
// the lookup observes the entry as it was before the update commits.

module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    input  logic [31:0]          lookup_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic                 upd_pred_taken,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Table storage. Only the valid bits are reset; tag/ctr/target are
    // don't-care until their entry has been allocated.
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [1:0]         ctr_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup path decode
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;
    logic                  lk_taken;
    logic [31:0]           lk_fallthrough;
    logic [31:0]           lk_target;

    assign lk_idx         = lookup_pc[INDEX_BITS+1:2];
    assign lk_tag         = lookup_pc[31:INDEX_BITS+2];
    assign lk_fallthrough = lookup_pc + 32'd4;

    // Hit detection and prediction selection for the fetch-side lookup.
    always_comb begin
        lk_hit    = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
        lk_taken  = lk_hit && ctr_mem[lk_idx][1];
        lk_target = lk_fallthrough;
        if (lk_taken) begin
            lk_target = target_mem[lk_idx];
        end
    end

    // ------------------------------------------------------------------
    // Update path decode
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]      up_tag;
    logic                  up_hit;
    logic [1:0]            up_ctr_cur;
    logic [1:0]            up_ctr_next;
    logic                  up_write_target;
    logic                  up_mispredict;

    // The two low PC bits never select an entry; instructions are word aligned.
    logic [1:0] unused_upd_pc_lo;
    assign unused_upd_pc_lo = upd_pc[1:0];

    assign up_idx     = upd_pc[INDEX_BITS+1:2];
    assign up_tag     = upd_pc[31:INDEX_BITS+2];
    assign up_ctr_cur = ctr_mem[up_idx];

    // Next counter value: saturating train on a hit, fresh weak state on allocate.
    always_comb begin
        up_hit          = valid_q[up_idx] && (tag_mem[up_idx] == up_tag);
        up_ctr_next     = CTR_WEAK_NT;
        up_write_target = 1'b1;
        if (up_hit) begin
            up_write_target = upd_taken;
            if (upd_taken) begin
                up_ctr_next = (up_ctr_cur == CTR_STRONG_T) ? CTR_STRONG_T
                                                            : up_ctr_cur + 2'd1;
            end else begin
                up_ctr_next = (up_ctr_cur == CTR_STRONG_NT) ? CTR_STRONG_NT
                                                             : up_ctr_cur - 2'd1;
            end
        end else begin
            up_ctr_next = upd_taken ? CTR_WEAK_T : CTR_WEAK_NT;
        end
    end

    assign up_mispredict = upd_valid && (upd_pred_taken != upd_taken);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    // Valid bits: cleared by reset, set by any update (hit or allocate).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Entry payload write; suppressed during reset so training is discarded.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid) begin
            tag_mem[up_idx] <= up_tag;
            ctr_mem[up_idx] <= up_ctr_next;
            if (up_write_target) begin
                target_mem[up_idx] <= upd_target;
            end
        end
    end

    // Registered prediction; fields hold when no lookup is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= 32'h0;
        end else if (lookup_valid) begin
            pred_valid  <= 1'b1;
            pred_taken  <= lk_taken;
            pred_target <= lk_target;
        end else begin
            pred_valid  <= 1'b0;
        end
    end

    // Saturating mispredict statistic.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_count <= '0;
        end else if (up_mispredict && (mispredict_count != CNT_MAX)) begin
            mispredict_count <= mispredict_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vectors with hand-computed
// expected predictions pushed into a scoreboard queue and popped by an
// independent monitor whenever pred_valid is seen. A second instance with a
// 4-bit statistic counter shares all inputs to exercise counter saturation.

module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;

    logic        pred_valid,  pred_valid4;
    logic        pred_taken,  pred_taken4;
    logic [31:0] pred_target, pred_target4;
    logic [15:0] mis_cnt;
    logic [3:0]  mis_cnt4;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {taken, target} per issued lookup.
    logic [32:0] exp_q[$];

    branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .mispredict_count(mis_cnt)
    );

    branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid4), .pred_taken(pred_taken4), .pred_target(pred_target4),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .mispredict_count(mis_cnt4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic lookup(input logic [31:0] pc, input logic exp_taken, input logic [31:0] exp_target);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        exp_q.push_back({exp_taken, exp_target});
        @(posedge clk); #1;
        lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic pt);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_pred_taken = pt;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    // Lookup and update on the same edge.
    task automatic collide(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic pt, input logic exp_taken, input logic [31:0] exp_target);
        lookup_valid   = 1'b1;
        lookup_pc      = pc;
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_pred_taken = pt;
        exp_q.push_back({exp_taken, exp_target});
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name, input logic [15:0] exp16, input logic [3:0] exp4);
        check({name, "_cnt16"}, {16'h0, mis_cnt}, {16'h0, exp16});
        check({name, "_cnt4"}, {28'h0, mis_cnt4}, {28'h0, exp4});
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst && pred_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pred: pred_valid=1 with no lookup outstanding at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pred_taken",   {31'h0, pred_taken},  {31'h0, e[32]});
                    check("pred_target",  pred_target,          e[31:0]);
                    check("pred_taken4",  {31'h0, pred_taken4}, {31'h0, e[32]});
                    check("pred_target4", pred_target4,         e[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        lookup_valid   = 1'b0;
        lookup_pc      = 32'h0;
        upd_valid      = 1'b0;
        upd_pc         = 32'h0;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_pred_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_pred_valid",  {31'h0, pred_valid}, 32'h0);
        check("rst_pred_taken",  {31'h0, pred_taken}, 32'h0);
        check("rst_pred_target", pred_target,         32'h0);
        check_counts("rst", 16'd0, 4'd0);

        // Cold miss
        lookup(32'h100, 1'b0, 32'h104);

        // Allocate taken, then train down with two not-taken updates
        update(32'h100, 1'b1, 32'h200, 1'b0);          // mispredict #1, ctr=10
        lookup(32'h100, 1'b1, 32'h200);
        update(32'h100, 1'b0, 32'h999, 1'b1);          // mispredict #2, ctr=01
        update(32'h100, 1'b0, 32'h999, 1'b0);          // ctr=00
        lookup(32'h100, 1'b0, 32'h104);
        check_counts("train", 16'd2, 4'd2);

        // Saturation at strong-taken
        repeat (5) update(32'h40, 1'b1, 32'h80, 1'b1); // ctr=11
        lookup(32'h40, 1'b1, 32'h80);
        update(32'h40, 1'b0, 32'h999, 1'b1);           // mispredict #3, ctr=10
        lookup(32'h40, 1'b1, 32'h80);
        update(32'h40, 1'b0, 32'h999, 1'b0);           // ctr=01
        lookup(32'h40, 1'b0, 32'h44);
        check_counts("sat", 16'd3, 4'd3);

        // Alias replacement: 0x100 and 0x200 share index 0
        update(32'h100, 1'b1, 32'h300, 1'b1);          // ctr 00->01, target 0x300
        update(32'h100, 1'b1, 32'h300, 1'b1);          // ctr=10
        lookup(32'h100, 1'b1, 32'h300);
        update(32'h200, 1'b0, 32'h500, 1'b0);          // replace, ctr=01
        lookup(32'h100, 1'b0, 32'h104);
        lookup(32'h200, 1'b0, 32'h204);                // back-to-back lookups

        // Same-cycle collision: read-before-write
        update(32'h100, 1'b0, 32'h600, 1'b0);          // reallocate 0x100 at weak-NT
        collide(32'h100, 1'b1, 32'h700, 1'b0, 1'b0, 32'h104); // mispredict #4
        lookup(32'h100, 1'b1, 32'h700);
        check_counts("collide", 16'd4, 4'd4);

        // Hold behaviour with lookup_valid low
        idle(1);
        check("hold_pred_valid",  {31'h0, pred_valid}, 32'h0);
        check("hold_pred_taken",  {31'h0, pred_taken}, 32'h1);
        check("hold_pred_target", pred_target,         32'h700);

        // 32-bit wrap of fall-through target
        lookup(32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Mispredict saturation on the 4-bit instance
        repeat (20) update(32'h40, 1'b1, 32'h80, 1'b0);
        check_counts("mis_sat", 16'd24, 4'd15);

        // Reset mid-operation; lookup and update presented during reset are ignored
        rst            = 1'b1;
        lookup_valid   = 1'b1;
        lookup_pc      = 32'h40;
        upd_valid      = 1'b1;
        upd_pc         = 32'h300;
        upd_taken      = 1'b1;
        upd_target     = 32'h900;
        upd_pred_taken = 1'b0;
        @(posedge clk); #1;
        rst          = 1'b0;
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        check("rst2_pred_valid",  {31'h0, pred_valid}, 32'h0);
        check("rst2_pred_taken",  {31'h0, pred_taken}, 32'h0);
        check("rst2_pred_target", pred_target,         32'h0);
        check_counts("rst2", 16'd0, 4'd0);
        lookup(32'h300, 1'b0, 32'h304);
        lookup(32'h40,  1'b0, 32'h44);
        lookup(32'h100, 1'b0, 32'h104);

        idle(3);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
